// File: rtl/ha_pkg.sv
// Shared defaults and helpers for the half-adder slice.
// Pure declarations; no timing or flow-control behaviour.
package ha_pkg;

  localparam int HA_WIDTH = 1;
  localparam int HA_CNT_W = 16;

  // Saturating add on a 32-bit carrier; callers pass their own ceiling.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] lim);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum > {1'b0, lim}) begin
      return lim;
    end
    return sum[31:0];
  endfunction

endpackage

// File: rtl/ha_cell.sv
// One-bit half adder: s_o = a_i ^ b_i, c_o = a_i & b_i.
// Combinational, zero latency; no flow control.
module ha_cell (
  input  logic a_i,
  input  logic b_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i;
  assign c_o = a_i & b_i;

endmodule

// File: rtl/half_adder.sv
// WIDTH-lane half adder: S/C combinational, S_R/C_R one cycle later; no backpressure.
// Optional saturating carry-event counter behind HALF_ADDER_STATS_EN.
module half_adder
  import ha_pkg::*;
#(
  parameter int WIDTH = HA_WIDTH,
  parameter int CNT_W = HA_CNT_W
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] S,
  output logic [WIDTH-1:0] C,
  output logic [WIDTH-1:0] S_R,
  output logic [WIDTH-1:0] C_R,
  output logic [CNT_W-1:0] CARRY_CNT
);

  logic [WIDTH-1:0] s_d, s_q;
  logic [WIDTH-1:0] c_d, c_q;

  // Lanes are independent: no carry chain between cells.
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    ha_cell u_cell (
      .a_i (A[i]),
      .b_i (B[i]),
      .s_o (S[i]),
      .c_o (C[i])
    );
  end

  assign s_d = S;
  assign c_d = C;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s_q <= '0;
      c_q <= '0;
    end else begin
      s_q <= s_d;
      c_q <= c_d;
    end
  end

  assign S_R = s_q;
  assign C_R = c_q;

`ifdef HALF_ADDER_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [31:0]      pop;

  // Carrier width of sat_add limits CNT_W to 32 bits.
  always_comb begin
    pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop = pop + 32'(C[i]);
    end
    cnt_d = CNT_W'(sat_add(32'(cnt_q), pop, 32'(CNT_MAX)));
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign CARRY_CNT = cnt_q;
`else
  assign CARRY_CNT = '0;
`endif

endmodule

// File: tb/tb_half_adder.sv
// Directed-vector bench for half_adder: WIDTH=1/CNT_W=2 and WIDTH=4 instances.
module tb_half_adder;

  logic       CLK;
  logic       RST;
  logic [0:0] A1, B1, S1, C1, SR1, CR1;
  logic [1:0] CNT1;
  logic [3:0] A4, B4, S4, C4, SR4, CR4;
  logic [15:0] CNT4;

  int vectors;
  int miscompares;

  half_adder #(.WIDTH(1), .CNT_W(2)) u_dut1 (
    .CLK       (CLK),
    .RST       (RST),
    .A         (A1),
    .B         (B1),
    .S         (S1),
    .C         (C1),
    .S_R       (SR1),
    .C_R       (CR1),
    .CARRY_CNT (CNT1)
  );

  half_adder #(.WIDTH(4), .CNT_W(16)) u_dut4 (
    .CLK       (CLK),
    .RST       (RST),
    .A         (A4),
    .B         (B4),
    .S         (S4),
    .C         (C4),
    .S_R       (SR4),
    .C_R       (CR4),
    .CARRY_CNT (CNT4)
  );

  // 20 ns period, rising edges at 10, 30, 50, ...
  initial CLK = 1'b0;
  always #10 CLK = ~CLK;

  task automatic test_reset();
    RST = 1'b1;
    A1 = 1'b1; B1 = 1'b0;
    A4 = 4'b0011; B4 = 4'b0101;
    #3;
    vectors++;
    if (SR1 !== 1'b0 || CR1 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_regs1: S_R=%b C_R=%b expected 0 0", SR1, CR1);
    end
    vectors++;
    if (CNT1 !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_cnt1: CARRY_CNT=%0d expected 0", CNT1);
    end
    vectors++;
    if (SR4 !== 4'b0000 || CR4 !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_regs4: S_R=%b C_R=%b expected 0000 0000", SR4, CR4);
    end
    vectors++;
    if (S1 !== 1'b1 || C1 !== 1'b0 || S4 !== 4'b0110 || C4 !== 4'b0001) begin
      miscompares++;
      $display("FAIL reset_comb: S1=%b C1=%b S4=%b C4=%b expected 1 0 0110 0001",
               S1, C1, S4, C4);
    end
    @(posedge CLK); #1;
    vectors++;
    if (SR1 !== 1'b0 || SR4 !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_held: S_R1=%b S_R4=%b expected 0 0000", SR1, SR4);
    end
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_exhaustive();
    logic [1:0] ab   [4] = '{2'b00, 2'b10, 2'b01, 2'b11};
    logic [1:0] sc   [4] = '{2'b00, 2'b10, 2'b10, 2'b01};
    for (int i = 0; i < 4; i++) begin
      logic [1:0] cur_ab;
      logic [1:0] cur_sc;
      cur_ab = ab[i];
      cur_sc = sc[i];
      @(negedge CLK);
      A1 = cur_ab[1]; B1 = cur_ab[0];
      #1;
      vectors++;
      if ({S1, C1} !== cur_sc) begin
        miscompares++;
        $display("FAIL truth_ab%b: S,C=%b%b expected %b", cur_ab, S1, C1, cur_sc);
      end
      @(posedge CLK); #1;
      vectors++;
      if ({SR1, CR1} !== cur_sc) begin
        miscompares++;
        $display("FAIL truth_reg_ab%b: S_R,C_R=%b%b expected %b", cur_ab, SR1, CR1, cur_sc);
      end
    end
  endtask

  task automatic test_registered();
    @(negedge CLK);
    A1 = 1'b0; B1 = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    A1 = 1'b1; B1 = 1'b1;
    #1;
    vectors++;
    if (CR1 !== 1'b0 || SR1 !== 1'b0) begin
      miscompares++;
      $display("FAIL reg_before_edge: C_R=%b S_R=%b expected 0 0", CR1, SR1);
    end
    @(posedge CLK); #1;
    vectors++;
    if (CR1 !== 1'b1 || SR1 !== 1'b0) begin
      miscompares++;
      $display("FAIL reg_one_edge: C_R=%b S_R=%b expected 1 0", CR1, SR1);
    end
  endtask

  task automatic test_async_reset();
    @(negedge CLK);
    A1 = 1'b1; B1 = 1'b0;
    @(posedge CLK); #1;
    vectors++;
    if (SR1 !== 1'b1) begin
      miscompares++;
      $display("FAIL areset_setup: S_R=%b expected 1", SR1);
    end
    #4;
    RST = 1'b1;
    #1;
    vectors++;
    if (SR1 !== 1'b0 || CR1 !== 1'b0) begin
      miscompares++;
      $display("FAIL areset_immediate: S_R=%b C_R=%b expected 0 0", SR1, CR1);
    end
    vectors++;
    if (S1 !== 1'b1 || C1 !== 1'b0) begin
      miscompares++;
      $display("FAIL areset_comb10: S=%b C=%b expected 1 0", S1, C1);
    end
    A1 = 1'b1; B1 = 1'b1;
    #1;
    vectors++;
    if (S1 !== 1'b0 || C1 !== 1'b1) begin
      miscompares++;
      $display("FAIL areset_comb11: S=%b C=%b expected 0 1", S1, C1);
    end
    @(posedge CLK); #1;
    vectors++;
    if (SR1 !== 1'b0 || CR1 !== 1'b0) begin
      miscompares++;
      $display("FAIL areset_held: S_R=%b C_R=%b expected 0 0", SR1, CR1);
    end
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK); #1;
    vectors++;
    if (SR1 !== 1'b0 || CR1 !== 1'b1) begin
      miscompares++;
      $display("FAIL areset_release: S_R=%b C_R=%b expected 0 1", SR1, CR1);
    end
  endtask

  task automatic test_width4();
    logic [3:0] va [3] = '{4'b1100, 4'b1111, 4'b0101};
    logic [3:0] vb [3] = '{4'b1010, 4'b1111, 4'b1010};
    logic [3:0] es [3] = '{4'b0110, 4'b0000, 4'b1111};
    logic [3:0] ec [3] = '{4'b1000, 4'b1111, 4'b0000};
    for (int i = 0; i < 3; i++) begin
      logic [3:0] xs;
      logic [3:0] xc;
      xs = es[i];
      xc = ec[i];
      @(negedge CLK);
      A4 = va[i]; B4 = vb[i];
      #1;
      vectors++;
      if (S4 !== xs || C4 !== xc) begin
        miscompares++;
        $display("FAIL w4_comb_%0d: S=%b C=%b expected %b %b", i, S4, C4, xs, xc);
      end
      @(posedge CLK); #1;
      vectors++;
      if (SR4 !== xs || CR4 !== xc) begin
        miscompares++;
        $display("FAIL w4_reg_%0d: S_R=%b C_R=%b expected %b %b", i, SR4, CR4, xs, xc);
      end
    end
  endtask

  task automatic test_stats();
`ifdef HALF_ADDER_STATS_EN
    logic [1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
`else
    logic [1:0] exp_cnt [5] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`endif
    @(negedge CLK);
    RST = 1'b1;
    A1 = 1'b1; B1 = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    #1;
    vectors++;
    if (CNT1 !== 2'd0) begin
      miscompares++;
      $display("FAIL stats_start: CARRY_CNT=%0d expected 0", CNT1);
    end
    for (int i = 0; i < 5; i++) begin
      logic [1:0] xc;
      xc = exp_cnt[i];
      @(posedge CLK); #1;
      vectors++;
      if (CNT1 !== xc) begin
        miscompares++;
        $display("FAIL stats_edge%0d: CARRY_CNT=%0d expected %0d", i + 1, CNT1, xc);
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    RST = 1'b1;
    A1 = '0; B1 = '0; A4 = '0; B4 = '0;
    test_reset();
    test_exhaustive();
    test_registered();
    test_async_reset();
    test_width4();
    test_stats();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
